// File: rtl/timer_counter_device_if.sv
`default_nettype none
// ============================================================================
// Module : timer_counter_device_if
// Bridge-side bus carrying address, write strobe/data, read data and irq.
// Rev    : 1.0
// ============================================================================
interface timer_counter_device_if;
    logic [31:0] addrOfDataInTimer;
    logic        writeEnabledOfTimer;
    logic [31:0] dataToTimer;
    logic [31:0] dataToRegFromTimer;
    logic        timerIrq;

    modport master (
        output addrOfDataInTimer,
        output writeEnabledOfTimer,
        output dataToTimer,
        input  dataToRegFromTimer,
        input  timerIrq
    );

    modport slave (
        input  addrOfDataInTimer,
        input  writeEnabledOfTimer,
        input  dataToTimer,
        output dataToRegFromTimer,
        output timerIrq
    );
endinterface
`default_nettype wire

// File: rtl/timer_counter_device.sv
`default_nettype none
// ============================================================================
// Module : timer_counter_device
// Memory-mapped countdown timer with one-shot / auto-reload modes and irq.
// Rev    : 1.0
// ============================================================================
module timer_counter_device (
    input  wire logic               clk,
    input  wire logic               resetN,
    timer_counter_device_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_next;
    logic        irq_pending, pending_next;
    logic        en_clear;

    logic [1:0]  reg_sel;
    logic        wr_ctrl, wr_preset;
    logic        en, im, auto_reload;
    logic        unused_addr_bits;

    assign reg_sel          = bus.addrOfDataInTimer[3:2];
    assign wr_ctrl          = bus.writeEnabledOfTimer && (reg_sel == 2'd0);
    assign wr_preset        = bus.writeEnabledOfTimer && (reg_sel == 2'd1);
    assign en               = ctrl[0];
    assign im               = ctrl[3];
    // MODE 10/11 fall back to one-shot, so only 01 reloads
    assign auto_reload      = (ctrl[2:1] == 2'b01);
    assign unused_addr_bits = ^{bus.addrOfDataInTimer[31:4], bus.addrOfDataInTimer[1:0]};

    always_comb begin
        state_next   = state;
        count_next   = count;
        pending_next = irq_pending;
        en_clear     = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = LOAD;
            end
            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // PRESET=0 lands here too, so it expires like PRESET=1
                    count_next   = 32'd0;
                    pending_next = 1'b1;
                    state_next   = INT;
                end
            end
            INT: begin
                if (auto_reload) pending_next = 1'b0;
                else             en_clear     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            ctrl        <= 4'd0;
            preset      <= 32'd0;
            count       <= 32'd0;
            irq_pending <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            // A software CTRL write wins over the FSM's one-shot EN clear
            if (wr_ctrl)       ctrl    <= bus.dataToTimer[3:0];
            else if (en_clear) ctrl[0] <= 1'b0;
            if (wr_preset)     preset  <= bus.dataToTimer;
            if (wr_ctrl || wr_preset) irq_pending <= 1'b0;
            else                      irq_pending <= pending_next;
        end
    end

    always_comb begin
        bus.dataToRegFromTimer = 32'd0;
        case (reg_sel)
            2'd0:    bus.dataToRegFromTimer = {28'd0, ctrl};
            2'd1:    bus.dataToRegFromTimer = preset;
            2'd2:    bus.dataToRegFromTimer = count;
            default: bus.dataToRegFromTimer = 32'd0;
        endcase
    end

    assign bus.timerIrq = im & irq_pending;
endmodule
`default_nettype wire

// File: tb/tb_timer_counter_device.sv
`default_nettype none
// ============================================================================
// Module : tb_timer_counter_device
// Directed scoreboard bench for the countdown timer.
// Rev    : 1.0
// ============================================================================
module tb_timer_counter_device;
    localparam logic [31:0] A_CTRL   = 32'h7F00;
    localparam logic [31:0] A_PRESET = 32'h7F04;
    localparam logic [31:0] A_COUNT  = 32'h7F08;
    localparam logic [31:0] A_RSVD   = 32'h7F0C;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    timer_counter_device_if bus ();

    timer_counter_device dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input logic [31:0] got);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, got, e);
        end
    endtask

    task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.addrOfDataInTimer = addr;
        #1;
        compare(bus.dataToRegFromTimer);
    endtask

    task automatic irq_check(input logic exp, input string tag);
        exp_q.push_back({31'd0, exp});
        tag_q.push_back(tag);
        compare({31'd0, bus.timerIrq});
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.addrOfDataInTimer   = addr;
        bus.dataToTimer         = data;
        bus.writeEnabledOfTimer = 1'b1;
        tick();
        bus.writeEnabledOfTimer = 1'b0;
    endtask

    initial begin
        logic [31:0] reload_tbl [6];
        logic [31:0] c;
        reload_tbl = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        bus.addrOfDataInTimer   = A_CTRL;
        bus.dataToTimer         = 32'd0;
        bus.writeEnabledOfTimer = 1'b0;

        // Power-on reset state
        #1;
        rd_check(A_CTRL,   32'd0, "rst_ctrl");
        rd_check(A_PRESET, 32'd0, "rst_preset");
        rd_check(A_COUNT,  32'd0, "rst_count");
        irq_check(1'b0, "rst_irq");
        tick(); tick();
        resetN = 1'b1;
        tick();

        // One-shot, PRESET=5
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            rd_check(A_COUNT, 32'(5 - i), $sformatf("oneshot_count_e%0d", i + 2));
            irq_check(1'b0, $sformatf("oneshot_noirq_e%0d", i + 2));
            tick();
        end
        rd_check(A_COUNT, 32'd0, "oneshot_count_e7");
        irq_check(1'b1, "oneshot_irq_e7");
        tick();
        rd_check(A_CTRL, 32'h8, "oneshot_en_cleared");
        irq_check(1'b1, "oneshot_irq_e8");
        tick(); tick(); tick();
        irq_check(1'b1, "oneshot_irq_held");
        wr(A_CTRL, 32'h8);
        irq_check(1'b0, "oneshot_irq_cleared");
        rd_check(A_CTRL, 32'h8, "oneshot_ctrl_after_clear");

        // Auto-reload, PRESET=3: period PRESET+3
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int n = 1; n < 20; n++) begin
            tick();
            if (n == 1) begin
                irq_check(1'b0, "reload_e1_irq");
            end else begin
                rd_check(A_COUNT, reload_tbl[(n - 2) % 6], $sformatf("reload_count_e%0d", n));
                irq_check(((n - 2) % 6) == 3, $sformatf("reload_irq_e%0d", n));
            end
        end
        wr(A_CTRL, 32'h8);
        tick(); tick();

        // Disable mid-count freezes COUNT without an irq
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        for (int i = 0; i < 8; i++) tick();
        rd_check(A_COUNT, 32'd4, "freeze_count_before");
        wr(A_CTRL, 32'h8);
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.addrOfDataInTimer = A_COUNT;
            #1;
            c = bus.dataToRegFromTimer;
            checks++;
            assert (c === 32'd3 || c === 32'd4) else begin
                errors++;
                $error("FAIL freeze_count_%0d: observed %h expected 3 or 4", i, c);
            end
            irq_check(1'b0, $sformatf("freeze_noirq_%0d", i));
            for (int j = 0; j < 5; j++) tick();
        end
        wr(A_CTRL, 32'h9);
        tick(); tick();
        rd_check(A_COUNT, 32'd10, "freeze_reload");
        tick();
        rd_check(A_COUNT, 32'd9, "freeze_reload_dec");
        wr(A_CTRL, 32'h0);
        tick(); tick();

        // PRESET=0 expires like PRESET=1, masked irq
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h1);
        tick(); tick();
        rd_check(A_COUNT, 32'd0, "zero_count_e2");
        tick();
        rd_check(A_COUNT, 32'd0, "zero_count_e3");
        irq_check(1'b0, "zero_irq_masked_e3");
        tick();
        rd_check(A_CTRL, 32'h0, "zero_en_cleared_e4");
        wr(A_CTRL, 32'h8);
        irq_check(1'b0, "zero_im_set_pending_cleared");
        tick();
        irq_check(1'b0, "zero_irq_stays_low");

        // COUNT and reserved slot ignore writes
        wr(A_COUNT, 32'hDEADBEEF);
        wr(A_RSVD, 32'h0000_0001);
        tick();
        rd_check(A_CTRL,   32'h8, "ign_ctrl");
        rd_check(A_PRESET, 32'd0, "ign_preset");
        rd_check(A_COUNT,  32'd0, "ign_count");
        rd_check(A_RSVD,   32'd0, "ign_rsvd_read");
        irq_check(1'b0, "ign_irq");

        // Read during write returns the old value
        bus.addrOfDataInTimer   = A_PRESET;
        bus.dataToTimer         = 32'd5;
        bus.writeEnabledOfTimer = 1'b1;
        #1;
        exp_q.push_back(32'd0);
        tag_q.push_back("rdw_old_value");
        compare(bus.dataToRegFromTimer);
        tick();
        bus.writeEnabledOfTimer = 1'b0;
        rd_check(A_PRESET, 32'd5, "rdw_new_value");

        // Asynchronous reset mid-count
        wr(A_CTRL, 32'hF);
        tick(); tick(); tick(); tick();
        rd_check(A_COUNT, 32'd3, "midrst_counting");
        #1;
        resetN = 1'b0;
        #1;
        rd_check(A_CTRL,   32'd0, "midrst_ctrl");
        rd_check(A_PRESET, 32'd0, "midrst_preset");
        rd_check(A_COUNT,  32'd0, "midrst_count");
        irq_check(1'b0, "midrst_irq");
        tick(); tick();
        resetN = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rd_check(A_COUNT, 32'd0, "postrst_count");
        rd_check(A_CTRL,  32'd0, "postrst_ctrl");
        irq_check(1'b0, "postrst_irq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
